// File: rtl/rice_block_decoder.sv
// Serial Rice split-sample block decoder: one compressed bit per cycle in,
// one block of up to JMAX 10-bit residuals plus reference sample out.
module rice_block_decoder #(
  parameter int N    = 10,
  parameter int JMAX = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  input  logic [5:0]        j,
  input  logic              ref_en,
  output logic [N*JMAX-1:0] symbol,
  output logic [N-1:0]      xref,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic              err
);

  localparam int SW = N * JMAX;

  typedef enum logic [2:0] {
    S_ID, S_REF, S_FS, S_SPLIT, S_RAW, S_OUT, S_ERR
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic           r_bit_ready;
  logic [3:0]     r_cnt;
  logic [N-1:0]   r_run;
  logic [N-2:0]   r_shift;
  logic [3:0]     r_k;
  logic           r_raw;
  logic [5:0]     r_j;
  logic [4:0]     r_idx;
  logic [SW-1:0]  r_symbol;
  logic [N-1:0]   r_xref;

  logic           w_fire;
  logic [N-1:0]   w_shift;
  logic [3:0]     w_id;
  logic           w_last;
  logic [N-1:0]   w_lim;
  logic           w_store;
  logic           w_field_done;
  logic [N-1:0]   w_value;

  assign w_fire  = bit_valid & r_bit_ready;
  assign w_shift = {r_shift, bit_in};
  assign w_id    = w_shift[3:0];
  assign w_last  = ({1'b0, r_idx} == r_j - 6'd1);
  assign w_lim   = {N{1'b1}} >> r_k;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    w_next       = r_state;
    w_store      = 1'b0;
    w_field_done = 1'b0;
    w_value      = '0;
    case (r_state)
      S_ID: if (w_fire && r_cnt == 4'd3) begin
        w_field_done = 1'b1;
        if ((w_id > 4'd8 && w_id != 4'hF) || j == 6'd0 || j > 6'd32) w_next = S_ERR;
        else if (ref_en)                                               w_next = S_REF;
        else if (w_id == 4'hF)                                         w_next = S_RAW;
        else                                                           w_next = S_FS;
      end
      S_REF: if (w_fire && r_cnt == 4'd9) begin
        w_field_done = 1'b1;
        w_next       = r_raw ? S_RAW : S_FS;
      end
      S_FS: if (w_fire) begin
        if (!bit_in) begin
          // Zero run about to exceed what still fits in N bits once shifted by k.
          if (r_run >= w_lim) w_next = S_ERR;
        end else if (r_k == 4'd0) begin
          w_store = 1'b1;
          w_value = r_run;
          w_next  = w_last ? S_OUT : S_FS;
        end else begin
          w_field_done = 1'b1;
          w_next       = S_SPLIT;
        end
      end
      S_SPLIT: if (w_fire && r_cnt == r_k - 4'd1) begin
        w_store = 1'b1;
        w_value = (r_run << r_k) | w_shift;
        w_next  = w_last ? S_OUT : S_FS;
      end
      S_RAW: if (w_fire && r_cnt == 4'd9) begin
        w_store = 1'b1;
        w_value = w_shift;
        w_next  = w_last ? S_OUT : S_RAW;
      end
      S_OUT:   if (blk_ready) w_next = S_ID;
      S_ERR:   w_next = S_ERR;
      default: w_next = S_ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the wide symbol register is reset because downstream may sample it as all-zero after reset.
      r_state     <= S_ID;
      r_bit_ready <= 1'b0;
      r_cnt       <= '0;
      r_run       <= '0;
      r_shift     <= '0;
      r_k         <= '0;
      r_raw       <= 1'b0;
      r_j         <= '0;
      r_idx       <= '0;
      r_symbol    <= '0;
      r_xref      <= '0;
    end else begin
      // NOTE: non-blocking throughout, so later assignments below override earlier ones cleanly.
      r_state     <= w_next;
      r_bit_ready <= (w_next inside {S_ID, S_REF, S_FS, S_SPLIT, S_RAW});
      if (w_fire) begin
        r_shift <= w_shift[N-2:0];
        r_cnt   <= r_cnt + 4'd1;
      end
      if (r_state == S_FS && w_fire && !bit_in) r_run <= r_run + 1'b1;
      if (w_field_done || w_store) begin
        r_shift <= '0;
        r_cnt   <= '0;
      end
      if (w_store) begin
        r_symbol[SW - 1 - N * int'(r_idx) -: N] <= w_value;
        r_idx <= r_idx + 5'd1;
        r_run <= '0;
      end
      if (r_state == S_ID && w_field_done) begin
        r_j      <= j;
        r_k      <= w_id;
        r_raw    <= (w_id == 4'hF);
        r_symbol <= '0;
        r_idx    <= '0;
        r_run    <= '0;
      end
      if (r_state == S_REF && w_field_done) r_xref <= w_shift;
    end
  end

  assign bit_ready = r_bit_ready;
  assign blk_valid = (r_state == S_OUT);
  assign err       = (r_state == S_ERR);
  assign symbol    = r_symbol;
  assign xref      = r_xref;

endmodule
